// File: rtl/ram_dump_pkg.sv
// rtl/ram_dump_pkg.sv - FSM encodings and UART frame constants shared by the RAM dump block
package ram_dump_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READ      = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_SEND_BYTE = 3'd3;
    localparam logic [2:0] ST_WAIT_TX   = 3'd4;
    localparam logic [2:0] ST_NEXT      = 3'd5;
    localparam logic [2:0] ST_CSUM      = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;

    // Frame is shifted out from bit 0, so the start bit sits at the LSB end.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_DATA_BITS-1:0] b);
        return {UART_STOP_BIT, b, UART_START_BIT};
    endfunction

endpackage

// File: rtl/ram_dump_uart_if.sv
// rtl/ram_dump_uart_if.sv - host/RAM/UART signal bundle of ram_dump_uart
interface ram_dump_uart_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              sendSig;
    logic [ADDR_W-1:0] startAddr;
    logic [ADDR_W-1:0] endAddr;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rs232_tx;
    logic              busy;
    logic              ok;

    modport master (output sendSig, startAddr, endAddr, data,
                    input  read, addr, rs232_tx, busy, ok);
    modport slave  (input  sendSig, startAddr, endAddr, data,
                    output read, addr, rs232_tx, busy, ok);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serialiser, CLK_DIV clocks per bit, done on the last stop-bit cycle
module uart_tx_byte
    import ram_dump_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(UART_FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_FRAME_BITS - 1);

    logic                       active_q, active_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic                       bit_end;

    assign bit_end = active_q && (div_q == DIV_LAST);
    assign done    = bit_end && (bit_q == BIT_LAST);
    assign tx      = active_q ? shift_q[0] : UART_STOP_BIT;

    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                shift_d  = uart_frame(byte_data);
                div_d    = '0;
                bit_d    = '0;
            end
        end else if (bit_end) begin
            div_d   = '0;
            shift_d = {UART_STOP_BIT, shift_q[UART_FRAME_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
                active_d = 1'b0;
                bit_d    = '0;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end
endmodule

// File: rtl/ram_dump_uart.sv
// rtl/ram_dump_uart.sv - dumps RAM words [startAddr..endAddr] over a UART; SEND_CHECKSUM_EN appends an XOR byte
module ram_dump_uart
    import ram_dump_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int CLK_DIV   = 868,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sendSig,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W-1:0] endAddr,
    output logic              read,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              rs232_tx,
    output logic              busy,
    output logic              ok
);
    localparam int NBYTES = DATA_W / 8;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(NBYTES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              busy_q, busy_d;
    logic              ok_q, ok_d;
    logic [7:0]        cur_byte, uart_byte;
    logic              tx_start, tx_done;
`ifdef SEND_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              csum_phase_q, csum_phase_d;
`endif

    assign read     = (state_q == ST_READ);
    assign addr     = addr_q;
    assign busy     = busy_q;
    assign ok       = ok_q;
    assign cur_byte = (MSB_FIRST != 0) ? word_q[DATA_W-1 -: 8] : word_q[7:0];
`ifdef SEND_CHECKSUM_EN
    assign uart_byte = (state_q == ST_CSUM) ? csum_q : cur_byte;
`else
    assign uart_byte = cur_byte;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = busy_q & ~ok_q;
        ok_d       = 1'b0;
        tx_start   = 1'b0;
`ifdef SEND_CHECKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // busy stays up through the ok cycle, so that cycle's sendSig is dropped too
                if (sendSig && !busy_q) begin
                    busy_d     = 1'b1;
                    addr_d     = startAddr;
                    end_d      = endAddr;
                    byte_cnt_d = '0;
`ifdef SEND_CHECKSUM_EN
                    csum_d       = 8'h00;
                    csum_phase_d = 1'b0;
`endif
                    state_d = (startAddr > endAddr) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                word_d     = data;
                byte_cnt_d = '0;
                state_d    = ST_SEND_BYTE;
            end
            ST_SEND_BYTE: begin
                tx_start = 1'b1;
`ifdef SEND_CHECKSUM_EN
                csum_d = csum_q ^ cur_byte;
`endif
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
`ifdef SEND_CHECKSUM_EN
                    if (csum_phase_q) state_d = ST_DONE;
                    else
`endif
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d = ST_NEXT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        word_d     = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
                        state_d    = ST_SEND_BYTE;
                    end
                end
            end
            ST_NEXT: begin
                // Equality stop: endAddr of all ones never wraps addr back to zero
                if (addr_q == end_q) begin
`ifdef SEND_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_READ;
                end
            end
`ifdef SEND_CHECKSUM_EN
            ST_CSUM: begin
                tx_start     = 1'b1;
                csum_phase_d = 1'b1;
                state_d      = ST_WAIT_TX;
            end
`endif
            ST_DONE: begin
                ok_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
`ifdef SEND_CHECKSUM_EN
            csum_q       <= 8'h00;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
`ifdef SEND_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tx_start),
        .byte_data (uart_byte),
        .tx        (rs232_tx),
        .done      (tx_done)
    );
endmodule

// File: doc/ram_dump_uart.md
RAM_DUMP_UART -- requirements
Module: ram_dump_uart

Interface
REQ-001 SHALL have parameter DATA_W, default 32: RAM word width, multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 16: RAM address width.
REQ-003 SHALL have parameter CLK_DIV, default 868: clk cycles per UART bit (100 MHz / 115200 baud).
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = most-significant byte of each word sent first.
REQ-005 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port sendSig, input, 1: one-cycle start pulse.
REQ-008 SHALL have ports startAddr and endAddr, input, ADDR_W each: inclusive dump range.
REQ-009 SHALL have port read, output, 1: RAM read strobe.
REQ-010 SHALL have port addr, output, ADDR_W: RAM read address.
REQ-011 SHALL have port data, input, DATA_W: RAM read data, valid the cycle after read.
REQ-012 SHALL have port rs232_tx, output, 1: UART serial out, idle high.
REQ-013 SHALL have port busy, output, 1: high from accepted sendSig until ok.
REQ-014 SHALL have port ok, output, 1: one-cycle done pulse.

Function
REQ-015 SHALL latch startAddr/endAddr on sendSig in IDLE; later changes to them are ignored.
REQ-016 SHALL ignore sendSig while busy is high.
REQ-017 SHALL use FSM states IDLE, READ, CAPTURE, SEND_BYTE, WAIT_TX, NEXT, (CSUM), DONE.
REQ-018 SHALL, in READ, assert read for exactly one cycle with addr = current address.
REQ-019 SHALL, in CAPTURE, register data (one-cycle RAM latency) into a word shift register.
REQ-020 SHALL send DATA_W/8 bytes per word, order per MSB_FIRST.
REQ-021 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLK_DIV cycles; frame = 10*CLK_DIV cycles.
REQ-022 SHALL start the next frame no later than 4 cycles after the previous stop bit ends.
REQ-023 SHALL, in NEXT, go to DONE when current address == endAddr, else increment and go to READ.
REQ-024 SHALL use an equality test for termination, so endAddr = all ones terminates with no address wrap.
REQ-025 SHALL, when startAddr > endAddr, send nothing, never assert read, and pulse ok 2 cycles after sendSig.
REQ-026 SHALL, when startAddr == endAddr, send exactly one word.
REQ-027 SHALL pulse ok for one cycle in DONE, then deassert busy and return to IDLE.

Reset
REQ-028 SHALL, while rst_n is low, force state IDLE, read=0, addr=0, rs232_tx=1, busy=0, ok=0, with the bit and byte counters cleared.
REQ-029 SHALL, on reset mid-frame, drive rs232_tx high immediately and emit no partial continuation after release.

Configuration
REQ-030 SHALL, with SEND_CHECKSUM_EN defined, send one extra byte after the last word's bytes (state CSUM): the XOR of all data bytes sent; ok follows that frame.
REQ-031 SHALL, without SEND_CHECKSUM_EN, omit the CSUM state and checksum logic; ok follows the last data byte.
REQ-032 SHALL send no checksum for an empty range (REQ-025), even with the macro defined.

Structure
REQ-033 SHALL place FSM state encodings and UART frame constants (start, stop, and data bit count) in shared package ram_dump_pkg.
REQ-034 SHALL implement bit timing and serialisation in sub-module uart_tx_byte (ports: clk, rst_n, start, byte, tx, done).

Verification
REQ-035 SHALL verify: start 0x1000, end 0x100F, DATA_W=32, RAM data = address -> 16 read pulses, 64 bytes in order 00 00 10 00, 00 00 10 01, ..., then one ok pulse.
REQ-036 SHALL verify: MSB_FIRST=0, data 0x12345678 at 0x0005, start = end = 0x0005 -> bytes 78 56 34 12, one read pulse.
REQ-037 SHALL verify: start 0x0010, end 0x000F -> no read, rs232_tx constantly 1, ok 2 cycles after sendSig.
REQ-038 SHALL verify: start 0xFFFE, end 0xFFFF -> exactly 2 reads (0xFFFE, 0xFFFF), then ok; addr never wraps to 0x0000.
REQ-039 SHALL verify: SEND_CHECKSUM_EN defined, word 0xA5A5_0F0F -> 5 frames, last byte 0x00; word 0x01020304 -> last byte 0x04.
REQ-040 SHALL verify: rst_n low 3000 cycles into a frame -> rs232_tx=1 and busy=0 that cycle; sendSig during busy has no effect; each bit lasts exactly 868 cycles.
